// File: rtl/mc_control_if.sv
// Control-unit boundary: instruction/status inputs and datapath select/enable outputs.
// master = controller side, slave = datapath side.
interface mc_control_if #(
    parameter int ALU_OP_W = 4
);
    logic [5:0]          opcode;
    logic                zero;
    logic                mem_ready;

    logic                reg_dst;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic                mem_to_reg;
    logic                iord;
    logic [1:0]          pc_src;

    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                pc_write;

    logic [ALU_OP_W-1:0] alu_op;
    logic [3:0]          state_o;
    logic                bus_err;

    modport master (
        input  opcode, zero, mem_ready,
        output reg_dst, alu_src_a, alu_src_b, mem_to_reg, iord, pc_src,
               reg_write, mem_read, mem_write, ir_write, pc_write,
               alu_op, state_o, bus_err
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  reg_dst, alu_src_a, alu_src_b, mem_to_reg, iord, pc_src,
               reg_write, mem_read, mem_write, ir_write, pc_write,
               alu_op, state_o, bus_err
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle MIPS-style Moore control FSM; outputs decode from current state (0-cycle), state advances per clk.
// Stalls in FETCH/MEM_RD/MEM_WR until mem_ready; data accesses give up after MEM_WAIT_MAX cycles with bus_err.
// Optional ILLEGAL_TRAP_EN: unknown opcodes and bus errors park the FSM in TRAP until rst.
module mc_control #(
    parameter int ALU_OP_W     = 4,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          rst,
    mc_control_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10
`ifdef ILLEGAL_TRAP_EN
        , TRAP   = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

    state_t     stateQ;
    state_t     stateNxt;
    logic [5:0] opLatch;
    logic [7:0] waitCnt;

    logic       inDataMem;
    logic       timeout;

    logic       regDst;
    logic       srcA;
    logic [1:0] srcB;
    logic       memToReg;
    logic       iorD;
    logic [1:0] pcSrc;
    logic       regWr;
    logic       memRd;
    logic       memWr;
    logic       irWr;
    logic       pcWr;
    logic [3:0] aluCode;
    logic       busErr;

    // Instruction fetch may stall indefinitely; only data accesses are bounded.
    assign inDataMem = (stateQ == MEM_RD) || (stateQ == MEM_WR);
    assign timeout   = inDataMem && !bus.mem_ready && (waitCnt == WAIT_LIMIT);

    function automatic logic [3:0] immAluCode(input logic [5:0] op);
        logic [3:0] code;
        code = 4'b0000;
        case (op)
            OP_ADDI: code = 4'b0101;
            OP_ANDI: code = 4'b0001;
            OP_ORI:  code = 4'b0010;
            OP_XORI: code = 4'b0011;
            OP_SLTI: code = 4'b1011;
            OP_LUI:  code = 4'b1010;
            default: code = 4'b0000;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= FETCH;
            opLatch <= 6'd0;
            waitCnt <= 8'd0;
        end else begin
            stateQ <= stateNxt;
            if (stateQ == DECODE) begin
                opLatch <= bus.opcode;
            end
            // Outside MEM_RD/MEM_WR the counter sits at zero, so each access starts clean.
            if (inDataMem && !bus.mem_ready) begin
                waitCnt <= waitCnt + 8'd1;
            end else begin
                waitCnt <= 8'd0;
            end
        end
    end

    always_comb begin
        stateNxt = stateQ;
        regDst   = 1'b0;
        srcA     = 1'b0;
        srcB     = 2'b00;
        memToReg = 1'b0;
        iorD     = 1'b0;
        pcSrc    = 2'b00;
        regWr    = 1'b0;
        memRd    = 1'b0;
        memWr    = 1'b0;
        irWr     = 1'b0;
        pcWr     = 1'b0;
        aluCode  = 4'b0000;
        busErr   = 1'b0;

        case (stateQ)
            FETCH: begin
                memRd = 1'b1;
                srcB  = 2'b01;
                irWr  = bus.mem_ready;
                pcWr  = bus.mem_ready;
                if (bus.mem_ready) begin
                    stateNxt = DECODE;
                end
            end

            DECODE: begin
                srcB = 2'b11;
                case (bus.opcode)
                    OP_RTYPE:                                   stateNxt = EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI,
                    OP_SLTI, OP_LUI:                            stateNxt = EXEC_I;
                    OP_LW, OP_SW:                               stateNxt = MEM_ADDR;
                    OP_BEQ, OP_BNE:                             stateNxt = BRANCH;
                    OP_J:                                       stateNxt = JUMP;
`ifdef ILLEGAL_TRAP_EN
                    default:                                    stateNxt = TRAP;
`else
                    default:                                    stateNxt = FETCH;
`endif
                endcase
            end

            EXEC_R: begin
                srcA     = 1'b1;
                aluCode  = 4'b1000;
                stateNxt = WB_ALU;
            end

            EXEC_I: begin
                srcA     = 1'b1;
                srcB     = 2'b10;
                aluCode  = immAluCode(opLatch);
                stateNxt = WB_ALU;
            end

            MEM_ADDR: begin
                srcA     = 1'b1;
                srcB     = 2'b10;
                stateNxt = (opLatch == OP_LW) ? MEM_RD : MEM_WR;
            end

            MEM_RD, MEM_WR: begin
                iorD   = 1'b1;
                memRd  = (stateQ == MEM_RD) && !timeout;
                memWr  = (stateQ == MEM_WR) && !timeout;
                busErr = timeout;
                if (bus.mem_ready) begin
                    stateNxt = (stateQ == MEM_RD) ? WB_MEM : FETCH;
                end else if (timeout) begin
`ifdef ILLEGAL_TRAP_EN
                    stateNxt = TRAP;
`else
                    stateNxt = FETCH;
`endif
                end
            end

            WB_ALU: begin
                regWr    = 1'b1;
                regDst   = (opLatch == OP_RTYPE);
                stateNxt = FETCH;
            end

            WB_MEM: begin
                regWr    = 1'b1;
                memToReg = 1'b1;
                stateNxt = FETCH;
            end

            BRANCH: begin
                srcA     = 1'b1;
                aluCode  = 4'b0110;
                pcSrc    = 2'b01;
                pcWr     = (opLatch == OP_BEQ) ? bus.zero : !bus.zero;
                stateNxt = FETCH;
            end

            JUMP: begin
                pcSrc    = 2'b10;
                pcWr     = 1'b1;
                stateNxt = FETCH;
            end

`ifdef ILLEGAL_TRAP_EN
            TRAP: begin
                aluCode  = 4'b1111;
                stateNxt = TRAP;
            end
`endif

            default: begin
                stateNxt = FETCH;
            end
        endcase
    end

    assign bus.reg_dst    = regDst;
    assign bus.alu_src_a  = srcA;
    assign bus.alu_src_b  = srcB;
    assign bus.mem_to_reg = memToReg;
    assign bus.iord       = iorD;
    assign bus.pc_src     = pcSrc;
    assign bus.reg_write  = regWr;
    assign bus.mem_read   = memRd;
    assign bus.mem_write  = memWr;
    assign bus.ir_write   = irWr;
    assign bus.pc_write   = pcWr;
    assign bus.alu_op     = ALU_OP_W'(aluCode);
    assign bus.state_o    = stateQ;
    assign bus.bus_err    = busErr;

endmodule

// File: tb/tb_mc_control.sv
// Instruction-level reference model for mc_control: each instruction expands into its expected
// per-cycle state/output trace, with random fetch/memory wait patterns and post-decode opcode noise.
module tb_mc_control;

    localparam int AW   = 5;
    localparam int WMAX = 3;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_control_if #(.ALU_OP_W(AW)) bus ();

    mc_control #(.ALU_OP_W(AW), .MEM_WAIT_MAX(WMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nVec = 0;
    int nMis = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic       z;
        logic       err;
        logic [5:0] drv;
    } cyc_t;

    logic [5:0] legalOps [12] = '{6'b000000, 6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010,
                                  6'b001111, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        nVec++;
        if (obs !== want) begin
            nMis++;
            $display("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    // 0 R-type, 1 immediate ALU, 2 lw, 3 sw, 4 branch, 5 jump, 6 unknown
    function automatic int opClass(input logic [5:0] op);
        case (op)
            6'b000000: return 0;
            6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001111: return 1;
            6'b100011: return 2;
            6'b101011: return 3;
            6'b000100, 6'b000101: return 4;
            6'b000010: return 5;
            default: return 6;
        endcase
    endfunction

    function automatic logic [3:0] immCode(input logic [5:0] op);
        case (op)
            6'b001000: return 4'b0101;
            6'b001100: return 4'b0001;
            6'b001101: return 4'b0010;
            6'b001110: return 4'b0011;
            6'b001010: return 4'b1011;
            6'b001111: return 4'b1010;
            default:   return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] expOut(input logic [3:0] st, input logic [5:0] op,
                                           input logic rdy, input logic z, input logic err);
        logic rd, sa, mtr, io, rw, mr, mw, iw, pw, be;
        logic [1:0] sb, ps;
        logic [3:0] ac;
        {rd, sa, mtr, io, rw, mr, mw, iw, pw, be} = 10'd0;
        sb = 2'b00; ps = 2'b00; ac = 4'b0000;
        case (st)
            4'd0:  begin mr = 1'b1; sb = 2'b01; iw = rdy; pw = rdy; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1'b1; ac = 4'b1000; end
            4'd3:  begin sa = 1'b1; sb = 2'b10; ac = immCode(op); end
            4'd4:  begin sa = 1'b1; sb = 2'b10; end
            4'd5:  begin io = 1'b1; mr = !err; be = err; end
            4'd6:  begin io = 1'b1; mw = !err; be = err; end
            4'd7:  begin rw = 1'b1; rd = (op == 6'b000000); end
            4'd8:  begin rw = 1'b1; mtr = 1'b1; end
            4'd9:  begin sa = 1'b1; ac = 4'b0110; ps = 2'b01; pw = (op == 6'b000100) ? z : !z; end
            4'd10: begin ps = 2'b10; pw = 1'b1; end
            4'd11: ac = 4'b1111;
            default: ;
        endcase
        return {13'd0, rd, sa, sb, mtr, io, ps, rw, mr, mw, iw, pw, AW'(ac), be};
    endfunction

    function automatic logic [31:0] obsOut();
        return {13'd0, bus.reg_dst, bus.alu_src_a, bus.alu_src_b, bus.mem_to_reg, bus.iord,
                bus.pc_src, bus.reg_write, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.pc_write, bus.alu_op, bus.bus_err};
    endfunction

    function automatic cyc_t mk(input int st, input logic rdy, input logic err, input logic [5:0] drv);
        cyc_t c;
        c.st  = 4'(st);
        c.rdy = rdy;
        c.z   = 1'($urandom);
        c.err = err;
        c.drv = drv;
        return c;
    endfunction

    task automatic step(input cyc_t c, input logic [5:0] op, input string tag);
        bus.opcode    = c.drv;
        bus.mem_ready = c.rdy;
        bus.zero      = c.z;
        @(negedge clk);
        chk($sformatf("%s op=%b st%0d state", tag, op, c.st), 32'(bus.state_o), 32'(c.st));
        chk($sformatf("%s op=%b st%0d outs", tag, op, c.st), obsOut(),
            expOut(c.st, op, c.rdy, c.z, c.err));
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input string tag);
        logic r;
        r             = 1'($urandom);
        rst           = 1'b1;
        bus.mem_ready = r;
        bus.zero      = 1'($urandom);
        bus.opcode    = 6'($urandom);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk({tag, " state"}, 32'(bus.state_o), 32'd0);
        chk({tag, " outs"}, obsOut(), expOut(4'd0, 6'd0, r, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // fw: fetch wait cycles, mw: data-access wait cycles, zf: forced zero flag in BRANCH (-1 = random)
    task automatic runInsn(input logic [5:0] op, input int fw, input int mw, input int zf, input string tag);
        cyc_t q[$];
        cyc_t c;
        int   k;
        int   ms;
        bit   trapped;
        k       = opClass(op);
        trapped = 1'b0;
        for (int i = 0; i < fw; i++) q.push_back(mk(0, 1'b0, 1'b0, op));
        q.push_back(mk(0, 1'b1, 1'b0, op));
        q.push_back(mk(1, 1'($urandom), 1'b0, op));
        case (k)
            0: begin q.push_back(mk(2, 1'($urandom), 1'b0, 6'($urandom)));
                     q.push_back(mk(7, 1'($urandom), 1'b0, 6'($urandom))); end
            1: begin q.push_back(mk(3, 1'($urandom), 1'b0, 6'($urandom)));
                     q.push_back(mk(7, 1'($urandom), 1'b0, 6'($urandom))); end
            2, 3: begin
                q.push_back(mk(4, 1'($urandom), 1'b0, 6'($urandom)));
                ms = (k == 2) ? 5 : 6;
                if (mw <= WMAX) begin
                    for (int i = 0; i < mw; i++) q.push_back(mk(ms, 1'b0, 1'b0, 6'($urandom)));
                    q.push_back(mk(ms, 1'b1, 1'b0, 6'($urandom)));
                    if (k == 2) q.push_back(mk(8, 1'($urandom), 1'b0, 6'($urandom)));
                end else begin
                    for (int i = 0; i < WMAX; i++) q.push_back(mk(ms, 1'b0, 1'b0, 6'($urandom)));
                    q.push_back(mk(ms, 1'b0, 1'b1, 6'($urandom)));
                    trapped = TRAP_EN;
                end
            end
            4: begin
                c = mk(9, 1'($urandom), 1'b0, 6'($urandom));
                if (zf >= 0) c.z = zf[0];
                q.push_back(c);
            end
            5: q.push_back(mk(10, 1'($urandom), 1'b0, 6'($urandom)));
            default: trapped = TRAP_EN;
        endcase
        if (trapped) begin
            for (int i = 0; i < 3; i++) q.push_back(mk(11, 1'($urandom), 1'b0, 6'($urandom)));
        end
        foreach (q[i]) step(q[i], op, tag);
        if (trapped) doReset({tag, " trap-exit reset"});
    endtask

    initial begin
        logic [5:0] op;
        bus.opcode    = 6'd0;
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;

        doReset("power-on reset");

        runInsn(6'b000000, 0, 0, -1, "add");
        runInsn(6'b100011, 1, 3, -1, "lw wait3");
        runInsn(6'b000100, 0, 0, 1, "beq z1");
        runInsn(6'b000100, 0, 0, 0, "beq z0");
        runInsn(6'b000101, 0, 0, 1, "bne z1");
        runInsn(6'b101011, 0, 20, -1, "sw timeout");
        runInsn(6'b100011, 0, 20, -1, "lw timeout");
        runInsn(6'b111111, 0, 0, -1, "illegal");
        foreach (legalOps[i]) runInsn(legalOps[i], 0, 0, -1, "sweep");

        // reset while a store is stalled
        step(mk(0, 1'b1, 1'b0, 6'b101011), 6'b101011, "sw-rst");
        step(mk(1, 1'b1, 1'b0, 6'b101011), 6'b101011, "sw-rst");
        step(mk(4, 1'b0, 1'b0, 6'($urandom)), 6'b101011, "sw-rst");
        step(mk(6, 1'b0, 1'b0, 6'($urandom)), 6'b101011, "sw-rst");
        doReset("reset in MEM_WR");

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else                           op = legalOps[$urandom_range(0, 11)];
            runInsn(op, $urandom_range(0, 2), $urandom_range(0, WMAX + 2), -1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter ALU_OP_W, default 4, sets the alu_op width; shall be at least 4, and codes are zero-extended.
REQ-002 Parameter MEM_WAIT_MAX, default 15, sets the cycles a memory access may wait for mem_ready before bus error; range 1..255.
REQ-003 One clock; reset is synchronous and active-high. Ports clk and rst are fixed as: clk in 1 (rising-edge clock); rst in 1 (synchronous, active-high reset).
REQ-004 Inputs:
- opcode in 6: instruction opcode, sampled in DECODE.
- zero in 1: ALU zero flag.
- mem_ready in 1: memory access complete.
REQ-005 Datapath select outputs:
- reg_dst out 1
- alu_src_a out 1
- alu_src_b out 2
- mem_to_reg out 1
- iord out 1
- pc_src out 2
REQ-006 Enable outputs:
- reg_write out 1
- mem_read out 1
- mem_write out 1
- ir_write out 1
- pc_write out 1
REQ-007 Other outputs:
- alu_op out ALU_OP_W: ALU operation code.
- state_o out 4: current state encoding.
- bus_err out 1: one-cycle error pulse.

Function
REQ-008 Moore FSM states and encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JUMP=10, TRAP=11; state_o shall show the current encoding.
REQ-009 FETCH shall drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=0000, pc_src=00; ir_write and pc_write shall equal mem_ready; the FSM stays in FETCH until mem_ready=1, then goes to DECODE.
REQ-010 DECODE shall drive alu_src_a=0, alu_src_b=11, alu_op=0000 (branch target) and shall dispatch in one cycle as follows:
- 000000 goes to EXEC_R.
- 001000, 001100, 001101, 001110, 001010 and 001111 go to EXEC_I.
- 100011 and 101011 go to MEM_ADDR.
- 000100 and 000101 go to BRANCH.
- 000010 goes to JUMP.
- Any other opcode goes to FETCH, or to TRAP per REQ-020.
REQ-011 EXEC_R shall drive alu_src_a=1, alu_src_b=00, alu_op=1000, then go to WB_ALU with reg_dst=1.
REQ-012 EXEC_I shall drive alu_src_a=1, alu_src_b=10, then go to WB_ALU with reg_dst=0. The alu_op codes are: addi 0101, andi 0001, ori 0010, xori 0011, slti 1011, lui 1010. The opcode shall be latched in DECODE so that later opcode changes have no effect.
REQ-013 WB_ALU shall assert reg_write=1 and mem_to_reg=0 for one cycle, then return to FETCH.
REQ-014 MEM_ADDR shall drive alu_src_a=1, alu_src_b=10, alu_op=0000, then go to MEM_RD for lw or MEM_WR for sw.
REQ-015 MEM_RD and MEM_WR:
- MEM_RD drives mem_read=1, iord=1; MEM_WR drives mem_write=1, iord=1.
- Both hold until mem_ready=1.
- On mem_ready, MEM_RD goes to WB_MEM and MEM_WR goes to FETCH.
- WB_MEM asserts reg_write=1, mem_to_reg=1, reg_dst=0, then goes to FETCH.
REQ-016 BRANCH shall drive alu_src_a=1, alu_src_b=00, alu_op=0110, pc_src=01. pc_write shall equal zero for beq and ~zero for bne. Next state is FETCH.
REQ-017 JUMP shall drive pc_src=10, pc_write=1, then go to FETCH.
REQ-018 Wait counter:
- An 8-bit counter clears on entry to any memory state and increments each cycle with mem_ready=0.
- When the counter equals MEM_WAIT_MAX with mem_ready still 0, bus_err pulses 1 for one cycle, no enable is asserted that cycle, and the FSM goes to FETCH (TRAP when ILLEGAL_TRAP_EN is defined).
- mem_ready=1 in that same cycle takes priority over the error.
REQ-019 Outputs not listed for a state shall be 0; no output may be X in any state.

Configuration
REQ-020 ILLEGAL_TRAP_EN:
- Defined: an unknown opcode in DECODE goes to TRAP. TRAP holds all enables at 0 and drives alu_op=1111, and is left only by rst.
- Undefined: the TRAP state does not exist, an unknown opcode returns to FETCH as a NOP, and a bus error returns to FETCH.

Reset
REQ-021 rst=1 at a clock edge shall force state FETCH, clear the wait counter, the latched opcode and bus_err, and override all other inputs, including mid-access.
REQ-022 After reset, outputs shall be FETCH values: mem_read=1, alu_src_b=01, all other outputs 0, with ir_write/pc_write following mem_ready.

Verification
REQ-023 Reset, then add (000000) with mem_ready=1 at all times -> states 0,1,2,7,0; reg_write=1 only in the WB_ALU cycle.
REQ-024 lw with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then WB_MEM with mem_to_reg=1 and reg_write=1.
REQ-025 beq with zero=1, then beq with zero=0 -> pc_write=1 in BRANCH for the first and 0 for the second; pc_src=01 in both.
REQ-026 sw with mem_ready held 0 and MEM_WAIT_MAX=3 -> bus_err=1 in exactly one cycle, mem_write deasserted that cycle, next state FETCH (undefined) or TRAP (defined).
REQ-027 Opcode 111111 -> with ILLEGAL_TRAP_EN, state_o=11 is held until rst, then 0; without it, the FSM returns to FETCH after DECODE.
REQ-028 rst asserted during MEM_WR -> next cycle state_o=0, mem_write=0, bus_err=0.
